// File: rtl/lcd_text_feeder_if.sv
`default_nettype none
// ============================================================================
// lcd_text_feeder_if : value input and LCD request outputs of lcd_text_feeder
// Revision 1.0
// ============================================================================
interface lcd_text_feeder_if;
  logic        value_valid;
  logic [15:0] value;
  logic        delete_req;
  logic        write_req;
  logic [7:0]  char_out;
  logic        busy;

  modport master (
    output value_valid, value,
    input  delete_req, write_req, char_out, busy
  );

  modport slave (
    input  value_valid, value,
    output delete_req, write_req, char_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/lcd_text_feeder.sv
`default_nettype none
// ============================================================================
// lcd_text_feeder : renders a ball X/Y value as "XX,YY" via toggle requests
// Revision 1.0
// ============================================================================
module lcd_text_feeder #(
  parameter logic [15:0] GAP_CYCLES = 16'd4096
) (
  input  wire logic        clk,
  input  wire logic        res_n,
  lcd_text_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GAP    = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4
  } state_t;

  localparam logic [15:0] GAP_LOAD  = GAP_CYCLES - 16'd2;
  localparam logic [2:0]  NUM_CHARS = 3'd5;

  state_t      state, state_nx;
  logic        delete_q, delete_nx;
  logic        write_q, write_nx;
  logic        busy_q, busy_nx;
  logic        pending, pending_nx;
  logic [7:0]  char_q, char_nx;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] work, work_nx;
  logic [15:0] pend_val, pend_val_nx;
  logic [2:0]  idx, idx_nx;
  logic [7:0]  next_char;
  logic [15:0] gap_exit;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  always_comb begin
    case (idx)
      3'd0:    next_char = hex_ascii(work[15:12]);
      3'd1:    next_char = hex_ascii(work[11:8]);
      3'd2:    next_char = 8'h2C;
      3'd3:    next_char = hex_ascii(work[7:4]);
      default: next_char = hex_ascii(work[3:0]);
    endcase
  end

  // Between two writes the STROBE cycle already counts toward the gap, so that
  // GAP leaves one count early; after CLEAR and after the last write it runs to 0.
  assign gap_exit = (idx != 3'd0 && idx != NUM_CHARS) ? 16'd1 : 16'd0;

  always_comb begin
    state_nx    = state;
    delete_nx   = delete_q;
    write_nx    = write_q;
    char_nx     = char_q;
    busy_nx     = busy_q;
    cnt_nx      = cnt;
    idx_nx      = idx;
    work_nx     = work;
    pending_nx  = pending;
    pend_val_nx = pend_val;

    if (state != IDLE && bus.value_valid) begin
      pending_nx  = 1'b1;
      pend_val_nx = bus.value;
    end

    case (state)
      IDLE: begin
        if (bus.value_valid || pending) begin
          work_nx    = bus.value_valid ? bus.value : pend_val;
          pending_nx = 1'b0;
          busy_nx    = 1'b1;
          idx_nx     = 3'd0;
          state_nx   = CLEAR;
        end
      end
      CLEAR: begin
        delete_nx = ~delete_q;
        cnt_nx    = GAP_LOAD;
        state_nx  = GAP;
      end
      GAP: begin
        if (cnt == gap_exit) begin
          if (idx == NUM_CHARS) begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            char_nx  = next_char;
            state_nx = SETUP;
          end
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      SETUP: begin
        write_nx = ~write_q;
        idx_nx   = idx + 3'd1;
        state_nx = STROBE;
      end
      STROBE: begin
        // With the minimum gap there is no room for a GAP cycle between writes.
        if (GAP_CYCLES == 16'd2 && idx != NUM_CHARS) begin
          char_nx  = next_char;
          state_nx = SETUP;
        end else begin
          cnt_nx   = GAP_LOAD;
          state_nx = GAP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= IDLE;
      delete_q <= 1'b0;
      write_q  <= 1'b0;
      char_q   <= 8'h20;
      busy_q   <= 1'b0;
      pending  <= 1'b0;
      cnt      <= 16'd0;
      idx      <= 3'd0;
      work     <= 16'd0;
      pend_val <= 16'd0;
    end else begin
      state    <= state_nx;
      delete_q <= delete_nx;
      write_q  <= write_nx;
      char_q   <= char_nx;
      busy_q   <= busy_nx;
      pending  <= pending_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      work     <= work_nx;
      pend_val <= pend_val_nx;
    end
  end

  assign bus.delete_req = delete_q;
  assign bus.write_req  = write_q;
  assign bus.char_out   = char_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_feeder.sv
`default_nettype none
// ============================================================================
// tb_lcd_text_feeder : directed vectors for lcd_text_feeder at gaps of 4 and 2
// Revision 1.0
// ============================================================================
module tb_lcd_text_feeder;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  lcd_text_feeder_if bus4();
  lcd_text_feeder_if bus2();

  lcd_text_feeder #(.GAP_CYCLES(16'd4)) dut4 (.clk(clk), .res_n(res_n), .bus(bus4));
  lcd_text_feeder #(.GAP_CYCLES(16'd2)) dut2 (.clk(clk), .res_n(res_n), .bus(bus2));

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic       m_del, m_wr, m_busy;
  logic [7:0] m_char;
  always_comb begin
    m_del  = (sel == 1) ? bus2.delete_req : bus4.delete_req;
    m_wr   = (sel == 1) ? bus2.write_req  : bus4.write_req;
    m_busy = (sel == 1) ? bus2.busy       : bus4.busy;
    m_char = (sel == 1) ? bus2.char_out   : bus4.char_out;
  end

  int         del_t[$];
  int         wr_t[$];
  logic [7:0] wr_ch[$];
  int         fall_t;

  typedef struct {
    int          sel;
    logic [15:0] v;
    logic [39:0] chars;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic vv, input logic [15:0] v);
    if (sel == 1) begin
      bus2.value_valid = vv;
      bus2.value       = v;
    end else begin
      bus4.value_valid = vv;
      bus4.value       = v;
    end
  endtask

  // Leaves the bench at the negedge right after the accept edge (cycle 0).
  task automatic pulse(input logic [15:0] v);
    @(negedge clk);
    drive(1'b1, v);
    @(negedge clk);
    drive(1'b0, 16'h0);
  endtask

  // Samples cycles 1..max_cyc, stopping at a busy fall; k1/k2 inject value pulses.
  task automatic capture(input int max_cyc, input int k1, input logic [15:0] v1,
                         input int k2, input logic [15:0] v2);
    logic       pd, pw, pb;
    logic [7:0] pc;
    del_t.delete();
    wr_t.delete();
    wr_ch.delete();
    fall_t = -1;
    pd = m_del; pw = m_wr; pb = m_busy; pc = m_char;
    for (int k = 1; k <= max_cyc && fall_t < 0; k++) begin
      @(negedge clk);
      if (m_del !== pd) del_t.push_back(k);
      if (m_wr !== pw) begin
        wr_t.push_back(k);
        wr_ch.push_back(pc);
      end
      if (pb === 1'b1 && m_busy === 1'b0) fall_t = k;
      pd = m_del; pw = m_wr; pb = m_busy; pc = m_char;
      if (k == k1)      drive(1'b1, v1);
      else if (k == k2) drive(1'b1, v2);
      else              drive(1'b0, 16'h0);
    end
    drive(1'b0, 16'h0);
  endtask

  task automatic check_seq(input string tag, input int gap, input int off, input logic [39:0] chars);
    check({tag, "_del_count"}, del_t.size(), 1);
    if (del_t.size() > 0) check({tag, "_del_cycle"}, del_t[0], 1 + off);
    check({tag, "_wr_count"}, wr_t.size(), 5);
    for (int i = 0; i < 5 && i < wr_t.size(); i++) begin
      check($sformatf("%s_wr%0d_cycle", tag, i), wr_t[i], 1 + off + gap * (i + 1));
      check($sformatf("%s_wr%0d_char", tag, i), {24'h0, wr_ch[i]}, {24'h0, chars[39 - 8 * i -: 8]});
    end
    check({tag, "_busy_fall"}, fall_t, 1 + off + 6 * gap);
  endtask

  initial begin
    bus4.value_valid = 1'b0; bus4.value = 16'h0;
    bus2.value_valid = 1'b0; bus2.value = 16'h0;

    vecs[0] = '{0, 16'h3A7F, 40'h33_41_2C_37_46};
    vecs[1] = '{0, 16'h0009, 40'h30_30_2C_30_39};
    vecs[2] = '{0, 16'hFFF0, 40'h46_46_2C_46_30};
    vecs[3] = '{0, 16'hA5C3, 40'h41_35_2C_43_33};
    vecs[4] = '{1, 16'hB4E1, 40'h42_34_2C_45_31};

    repeat (3) @(negedge clk);
    check("rst_del4",  {31'h0, bus4.delete_req}, 0);
    check("rst_wr4",   {31'h0, bus4.write_req},  0);
    check("rst_char4", {24'h0, bus4.char_out},   32'h20);
    check("rst_busy4", {31'h0, bus4.busy},       0);
    check("rst_char2", {24'h0, bus2.char_out},   32'h20);
    check("rst_busy2", {31'h0, bus2.busy},       0);

    res_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_del4",  {31'h0, bus4.delete_req}, 0);
    check("post_rst_char4", {24'h0, bus4.char_out},   32'h20);
    check("post_rst_busy4", {31'h0, bus4.busy},       0);

    for (int n = 0; n < 5; n++) begin
      sel = vecs[n].sel;
      pulse(vecs[n].v);
      capture(60, -1, 16'h0, -1, 16'h0);
      check_seq($sformatf("vec%0d", n), (vecs[n].sel == 1) ? 2 : 4, 0, vecs[n].chars);
    end
    sel = 0;

    // Two pulses while busy: the current text is unaffected, only the newer one follows.
    pulse(16'h3A7F);
    capture(60, 3, 16'h1111, 10, 16'h2222);
    check_seq("ovw_cur", 4, 0, 40'h33_41_2C_37_46);
    capture(60, -1, 16'h0, -1, 16'h0);
    check_seq("ovw_next", 4, 1, 40'h32_32_2C_32_32);
    capture(40, -1, 16'h0, -1, 16'h0);
    check("ovw_extra_del", del_t.size(), 0);
    check("ovw_extra_wr",  wr_t.size(),  0);

    // Pulse landing on the edge where busy falls.
    pulse(16'h3A7F);
    capture(60, 24, 16'h0009, -1, 16'h0);
    check_seq("fall_cur", 4, 0, 40'h33_41_2C_37_46);
    capture(60, -1, 16'h0, -1, 16'h0);
    check_seq("fall_next", 4, 1, 40'h30_30_2C_30_39);

    // Asynchronous reset between the 2nd and 3rd write.
    pulse(16'hFFF0);
    capture(11, -1, 16'h0, -1, 16'h0);
    check("abort_wr_before", wr_t.size(), 2);
    check("abort_del_before", {31'h0, bus4.delete_req}, 1);
    #2 res_n = 1'b0;
    #1;
    check("abort_del",  {31'h0, bus4.delete_req}, 0);
    check("abort_wr",   {31'h0, bus4.write_req},  0);
    check("abort_char", {24'h0, bus4.char_out},   32'h20);
    check("abort_busy", {31'h0, bus4.busy},       0);
    @(negedge clk);
    res_n = 1'b1;
    capture(40, -1, 16'h0, -1, 16'h0);
    check("abort_after_del",  del_t.size(), 0);
    check("abort_after_wr",   wr_t.size(),  0);
    check("abort_after_char", {24'h0, bus4.char_out}, 32'h20);
    check("abort_after_busy", {31'h0, bus4.busy},     0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
